// File: rtl/pattern_writer_pkg.sv
// Shared constants, FSM encoding and helpers for the pattern stamper.
package pattern_writer_pkg;

  localparam int MAX_X   = 32;
  localparam int MAX_Y   = 24;
  localparam int ADDR_W  = 10;
  localparam int PAT_DIM = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/coord_wrap.sv
// Toroidal coordinate step: (base + offset) mod LIMIT, with base already below LIMIT.
module coord_wrap #(
  parameter int LIMIT = 32
) (
  input  logic [7:0] base,
  input  logic [2:0] offset,
  output logic [7:0] result
);

  logic [8:0] sum;

  // Repeated compare-and-subtract also covers grids narrower than the pattern.
  always_comb begin
    sum = {1'b0, base} + {6'b0, offset};
    for (int i = 0; i < 8; i++) begin
      if (32'(sum) >= LIMIT) sum = sum - 9'(LIMIT);
    end
    result = sum[7:0];
  end

endmodule

// File: rtl/pattern_writer.sv
// Stamps an 8x8 pattern onto a toroidal cell grid, one registered write per cycle.
module pattern_writer #(
  parameter int MAX_X  = pattern_writer_pkg::MAX_X,
  parameter int MAX_Y  = pattern_writer_pkg::MAX_Y,
  parameter int ADDR_W = pattern_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [7:0]        cursor_x,
  input  logic [7:0]        cursor_y,
  input  logic [63:0]       pattern_mat,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [6:0]        set_count
);

  import pattern_writer_pkg::*;

  localparam int CELLS = PAT_DIM * PAT_DIM;

  state_t state, next_state;

  logic [5:0]  cnt, next_k;
  logic [63:0] lat_pat, src_pat;
  logic        lat_mode, src_mode;
  logic [7:0]  lat_cx, lat_cy, in_cx, in_cy, src_cx, src_cy;
  logic [7:0]  x_w, y_w;
  logic        accept;

  logic              busy_nx, done_nx, wr_en_nx, wr_data_nx;
  logic [ADDR_W-1:0] wr_addr_nx;

  assign accept = (state == IDLE) && start;
  assign in_cx  = (32'(cursor_x) >= MAX_X) ? 8'd0 : cursor_x;
  assign in_cy  = (32'(cursor_y) >= MAX_Y) ? 8'd0 : cursor_y;

  // On the accepting edge the first cell is built from the live inputs so it can be registered at once.
  assign src_pat  = accept ? pattern_mat : lat_pat;
  assign src_mode = accept ? mode        : lat_mode;
  assign src_cx   = accept ? in_cx       : lat_cx;
  assign src_cy   = accept ? in_cy       : lat_cy;
  assign next_k   = accept ? 6'd0        : cnt + 6'd1;

  coord_wrap #(.LIMIT(MAX_X)) u_wrap_x (
    .base   (src_cx),
    .offset (next_k[2:0]),
    .result (x_w)
  );

  coord_wrap #(.LIMIT(MAX_Y)) u_wrap_y (
    .base   (src_cy),
    .offset (next_k[5:3]),
    .result (y_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = WRITE;
      WRITE:   if (cnt == 6'(CELLS - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Values the output registers take at the coming edge.
  always_comb begin
    busy_nx    = (next_state != IDLE);
    done_nx    = (next_state == DONE);
    wr_en_nx   = 1'b0;
    wr_data_nx = 1'b0;
    wr_addr_nx = '0;
    if (next_state == WRITE) begin
      wr_en_nx   = src_mode | src_pat[next_k];
      wr_data_nx = src_pat[next_k];
      wr_addr_nx = ADDR_W'(32'(y_w) * MAX_X + 32'(x_w));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_pat   <= '0;
      lat_mode  <= 1'b0;
      lat_cx    <= '0;
      lat_cy    <= '0;
      set_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= 1'b0;
      wr_addr   <= '0;
    end else begin
      if (accept) begin
        lat_pat   <= pattern_mat;
        lat_mode  <= mode;
        lat_cx    <= in_cx;
        lat_cy    <= in_cy;
        set_count <= popcount64(pattern_mat);
      end
      cnt     <= (next_state == WRITE) ? next_k : 6'd0;
      busy    <= busy_nx;
      done    <= done_nx;
      wr_en   <= wr_en_nx;
      wr_data <= wr_data_nx;
      wr_addr <= wr_addr_nx;
    end
  end

endmodule

// File: tb/tb_pattern_writer.sv
// Scoreboard bench: stimulus pushes the reference write sequence, a negedge monitor checks every cycle.
module tb_pattern_writer;

  localparam int MX = 32;
  localparam int MY = 24;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [7:0]    cursor_x, cursor_y;
  logic [63:0]   pattern_mat;
  logic          busy, done, wr_en, wr_data;
  logic [AW-1:0] wr_addr;
  logic [6:0]    set_count;

  pattern_writer #(.MAX_X(MX), .MAX_Y(MY), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .pattern_mat (pattern_mat),
    .busy        (busy),
    .done        (done),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .set_count   (set_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    int   k;
    logic en;
    int   addr;
    logic data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_lo = -1;
  int   busy_hi = -2;
  int   exp_cnt = 0;
  bit   mon_on = 1'b0;
  int   log_addr[64];
  logic log_en[64];
  logic log_data[64];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every cycle is either a scheduled write or must show idle write outputs.
  always @(negedge clk) begin
    if (mon_on) begin
      exp_t e;
      checkOutput("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checkOutput("missed_write", e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checkOutput("wr_en", wr_en, e.en);
        checkOutput("wr_addr", wr_addr, e.addr);
        checkOutput("wr_data", wr_data, e.data);
        log_en[e.k]   = wr_en;
        log_addr[e.k] = int'(wr_addr);
        log_data[e.k] = wr_data;
      end else begin
        checkOutput("idle_wr_en", wr_en, 0);
        checkOutput("idle_wr_addr", wr_addr, 0);
        checkOutput("idle_wr_data", wr_data, 0);
      end
      if (cyc == busy_hi) begin
        checkOutput("done", done, 1);
        checkOutput("set_count", set_count, exp_cnt);
      end else begin
        checkOutput("no_done", done, 0);
      end
    end
  end

  // Reference: cell k lands on ((cx+c) mod MX, (cy+r) mod MY) after clamping the cursor.
  task automatic applyStimulus(input logic m, input int cx, input int cy, input logic [63:0] pat);
    int t, cxe, cye, x, y;
    exp_t e;
    mode = m; cursor_x = 8'(cx); cursor_y = 8'(cy); pattern_mat = pat;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = cyc;
    cxe = (cx >= MX) ? 0 : cx;
    cye = (cy >= MY) ? 0 : cy;
    for (int k = 0; k < 64; k++) begin
      log_en[k] = 1'b0; log_addr[k] = -1; log_data[k] = 1'b0;
      x = (cxe + k % 8) % MX;
      y = (cye + k / 8) % MY;
      e.cyc = t + k; e.k = k; e.en = m | pat[k]; e.addr = y * MX + x; e.data = pat[k];
      exp_q.push_back(e);
    end
    busy_lo = t;
    busy_hi = t + 64;
    exp_cnt = $countones(pat);
  endtask

  task automatic finishStamp(input int edges_used);
    repeat (66 - edges_used) @(posedge clk);
    #1;
  endtask

  function automatic int enCount();
    int n = 0;
    for (int k = 0; k < 64; k++) n += int'(log_en[k]);
    return n;
  endfunction

  initial begin
    logic [63:0] pat;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    cursor_x = '0; cursor_y = '0; pattern_mat = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_set_count", set_count, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Glider in OR mode
    pat = '0;
    pat[1] = 1'b1; pat[10] = 1'b1; pat[16] = 1'b1; pat[17] = 1'b1; pat[18] = 1'b1;
    applyStimulus(1'b0, 3, 2, pat);
    finishStamp(1);
    checkOutput("glider_writes", enCount(), 5);
    checkOutput("glider_a1", log_addr[1], 68);
    checkOutput("glider_a10", log_addr[10], 101);
    checkOutput("glider_a16", log_addr[16], 131);
    checkOutput("glider_a17", log_addr[17], 132);
    checkOutput("glider_a18", log_addr[18], 133);
    checkOutput("glider_d18", log_data[18], 1);

    // Corner wrap, overwrite
    applyStimulus(1'b1, 30, 22, {64{1'b1}});
    finishStamp(1);
    checkOutput("corner_writes", enCount(), 64);
    checkOutput("corner_a0", log_addr[0], 734);
    checkOutput("corner_a2", log_addr[2], 704);
    checkOutput("corner_a16", log_addr[16], 30);
    checkOutput("corner_a63", log_addr[63], 165);

    // Overwrite clear
    applyStimulus(1'b1, 5, 7, 64'd0);
    finishStamp(1);
    checkOutput("clear_writes", enCount(), 64);
    checkOutput("clear_data0", log_data[0], 0);

    // Inputs changed and start re-pulsed while busy
    applyStimulus(1'b0, 10, 4, 64'h0000_0018_2400_8100);
    repeat (4) @(posedge clk);
    #1;
    pattern_mat = 64'hFFFF_FFFF_FFFF_FFFF; mode = 1'b1; cursor_x = 8'd1; cursor_y = 8'd1;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finishStamp(10);

    // Reset mid-stamp aborts; rst then wins over a simultaneous start
    applyStimulus(1'b1, 8, 8, 64'hA5A5_5A5A_0F0F_F0F0);
    repeat (18) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    busy_lo = -1; busy_hi = -2;
    checkOutput("abort_set_count", set_count, 0);
    checkOutput("abort_busy", busy, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    checkOutput("rst_prio_busy", busy, 0);
    repeat (3) @(posedge clk); #1;
    applyStimulus(1'b0, 0, 0, 64'h8000_0000_0000_0001);
    finishStamp(1);
    checkOutput("after_abort_writes", enCount(), 2);

    // Out-of-range cursor clamps to the origin
    applyStimulus(1'b0, 40, 30, 64'd1);
    finishStamp(1);
    checkOutput("oor_writes", enCount(), 1);
    checkOutput("oor_a0", log_addr[0], 0);

    // Random stamps, occasionally back-to-back with no idle gap
    for (int i = 0; i < 20; i++) begin
      pat = {$urandom, $urandom} & {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 39), $urandom_range(0, 29), pat);
      finishStamp(1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk); #1;
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_writer.md
PATTERN_WRITER -- requirements
Module: pattern_writer

Interface
REQ-001 Parameter MAX_X, default 32: grid width in cells.
REQ-002 Parameter MAX_Y, default 24: grid height in cells.
REQ-003 Parameter ADDR_W, default 10: cell address width, with MAX_X*MAX_Y <= 2^ADDR_W.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 start  input  1: request to stamp a pattern; sampled only in IDLE.
REQ-007 mode  input  1: 0 = OR mode (write live cells only), 1 = overwrite mode (write all 64 cells).
REQ-008 cursor_x  input  8: column of the pattern's top-left cell.
REQ-009 cursor_y  input  8: row of the pattern's top-left cell.
REQ-010 pattern_mat  input  64: 8x8 pattern; bit r*8+c is pattern row r, column c; 1 = alive.
REQ-011 busy  output  1: high while a stamp is in progress.
REQ-012 done  output  1: one-cycle pulse when a stamp completes.
REQ-013 wr_en  output  1: grid write strobe.
REQ-014 wr_addr  output  ADDR_W: written cell index, y*MAX_X + x.
REQ-015 wr_data  output  1: value written to the cell.
REQ-016 set_count  output  7: number of 1 bits in the latched pattern (0..64).

Function
REQ-017 FSM states: IDLE, WRITE, DONE.
- IDLE -> WRITE when start=1.
- WRITE -> DONE after the 64th cell.
- DONE -> IDLE unconditionally.
REQ-018 On the edge where IDLE sees start=1, latch pattern_mat, mode, cursor_x and cursor_y. Input changes after this edge have no effect on the stamp.
REQ-019 A latched cursor_x >= MAX_X is replaced by 0. A latched cursor_y >= MAX_Y is replaced by 0.
REQ-020 WRITE lasts exactly 64 cycles and visits cell k = 0..63 in order, with r = k/8 and c = k%8.
REQ-021 Target coordinates for cell k:
- x = (cx + c) mod MAX_X
- y = (cy + r) mod MAX_Y
- Wrap-around is toroidal. Implement it with compare-and-subtract; no divider.
REQ-022 In WRITE:
- wr_addr = y*MAX_X + x; wr_data = pattern bit k.
- wr_en = 1 if mode=1, or if mode=0 and bit k = 1.
REQ-023 Outside WRITE: wr_en=0, wr_addr=0, wr_data=0.
REQ-024 Timing: start sampled at edge T; writes are presented in cycles T+1..T+64; done=1 in cycle T+65; the FSM is back in IDLE at T+66.
REQ-025 busy=1 in WRITE and DONE, 0 in IDLE.
REQ-026 start is ignored while busy=1. Requests are not queued.
REQ-027 set_count:
- Updated to popcount(latched pattern) on the latch edge.
- Holds its value until the next accepted start.
- Valid in DONE.
REQ-028 Every output is registered. There is no combinational path from any input to any output.
REQ-029 If the pattern wraps onto the same cell twice (only possible when MAX_X < 8 or MAX_Y < 8), write both in order; the later write wins.

Reset
REQ-030 While rst=1, at the next edge:
- State goes to IDLE.
- busy, done, wr_en, wr_data, wr_addr and set_count go to 0.
- Latched registers are cleared.
REQ-031 rst asserted during WRITE aborts the stamp immediately: no further wr_en and no done pulse.
REQ-032 rst has priority over start in the same cycle.

Structure
REQ-033 Shared package contents:
- Constants MAX_X, MAX_Y, ADDR_W and PAT_DIM=8.
- The FSM state encoding.
REQ-034 One sub-module, coord_wrap, computes (base + offset) mod limit for a 3-bit offset. It is instantiated twice, for x and for y.
REQ-035 Cell counter: 6 bits. Row/column are its upper/lower 3 bits.

Verification
REQ-036 Glider OR stamp:
- Stimulus: pattern bits {1,10,16,17,18} set, mode=0, cursor (3,2), start pulse.
- Response: exactly 5 wr_en cycles with wr_data=1, at addresses 68, 101, 131, 132, 133; done at T+65; set_count=5.
REQ-037 Corner wrap:
- Stimulus: pattern=all ones, mode=1, cursor (30,22).
- Response: 64 writes. Cell 0 -> addr 734; cell 2 -> x=0, addr 704; cell 16 -> y=0, x=30, addr 30; cell 63 -> (5,5), addr 165.
REQ-038 Overwrite clear:
- Stimulus: pattern=0, mode=1.
- Response: 64 cycles with wr_en=1 and wr_data=0; set_count=0.
REQ-039 Busy ignore:
- Stimulus: start re-pulsed at T+10; pattern_mat changed at T+5.
- Response: a single done pulse; writes reflect the pattern latched at T.
REQ-040 Reset mid-stamp:
- Stimulus: rst=1 at T+20.
- Response: from T+21, wr_en=0, busy=0, set_count=0, and no done pulse. A new start at T+25 completes normally.
REQ-041 Out-of-range cursor:
- Stimulus: cursor (40,30) with pattern bit 0 set.
- Response: single write at addr 0.
